// File: rtl/seg_scan_595_ctrl.sv
// rtl/seg_scan_595_ctrl.sv - six-digit 7-segment scan controller driving two cascaded 74HC595s
// Optional leading-zero suppression is enabled by defining SEG_LZ_SUPPRESS_EN.
module seg_scan_595_ctrl #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned SCAN_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] data_in,
    input  logic [5:0]  point_in,
    input  logic [5:0]  blank_in,
    input  logic        load,
    input  logic        seg_en,
    output logic        frame_done,
    output logic        stcp,
    output logic        shcp,
    output logic        ds,
    output logic        oe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LATCH,
        S_DWELL
    } state_t;

    localparam logic [31:0] DIV_LAST  = 32'(CLK_DIV - 1);
    localparam logic [31:0] SCAN_LAST = 32'(SCAN_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [13:0] word_q, word_d;
    logic [2:0]  digit_q, digit_d;
    logic [23:0] act_data_q, act_data_d, pend_data_q, pend_data_d;
    logic [5:0]  act_point_q, act_point_d, pend_point_q, pend_point_d;
    logic [5:0]  act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
    logic        pend_valid_q, pend_valid_d;
    logic        shown_q, shown_d;
    logic        stcp_q, stcp_d, shcp_q, shcp_d, ds_q, ds_d, oe_q, oe_d;
    logic        boundary;
    logic [5:0]  lz;
    logic [3:0]  nib;
    logic [7:0]  seg_n;
    logic [5:0]  sel;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_to_seg = 8'hC0;
            4'h1: hex_to_seg = 8'hF9;
            4'h2: hex_to_seg = 8'hA4;
            4'h3: hex_to_seg = 8'hB0;
            4'h4: hex_to_seg = 8'h99;
            4'h5: hex_to_seg = 8'h92;
            4'h6: hex_to_seg = 8'h82;
            4'h7: hex_to_seg = 8'hF8;
            4'h8: hex_to_seg = 8'h80;
            4'h9: hex_to_seg = 8'h90;
            4'hA: hex_to_seg = 8'h88;
            4'hB: hex_to_seg = 8'h83;
            4'hC: hex_to_seg = 8'hC6;
            4'hD: hex_to_seg = 8'hA1;
            4'hE: hex_to_seg = 8'h86;
            default: hex_to_seg = 8'h8E;
        endcase
    endfunction

`ifdef SEG_LZ_SUPPRESS_EN
    logic lz_run;

    // A digit is a leading zero while it and every higher digit are zero without a point.
    always_comb begin
        lz_run = 1'b1;
        lz     = '0;
        for (int i = 5; i >= 1; i--) begin
            lz_run = lz_run & (act_data_q[4*i +: 4] == 4'd0) & ~act_point_q[i];
            lz[i]  = lz_run;
        end
    end
`else
    assign lz = '0;
`endif

    always_comb begin
        nib   = act_data_q[{digit_q, 2'b00} +: 4];
        seg_n = hex_to_seg(nib);
        if (act_point_q[digit_q]) begin
            seg_n[7] = 1'b0;
        end
        if (act_blank_q[digit_q] | lz[digit_q]) begin
            seg_n = 8'hFF;
        end
        sel = 6'd1 << digit_q;
    end

    assign boundary = (state_q == S_DWELL) && (cnt_q == 32'd0) && (digit_q == 3'd5);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        word_d   = word_q;
        digit_d  = digit_q;
        shown_d  = shown_q;
        stcp_d   = stcp_q;
        shcp_d   = shcp_q;
        ds_d     = ds_q;
        case (state_q)
            S_IDLE: state_d = S_LOAD;
            S_LOAD: begin
                word_d   = {seg_n, sel};
                bitcnt_d = 4'd13;
                ds_d     = word_d[13];
                shcp_d   = 1'b0;
                cnt_d    = DIV_LAST;
                state_d  = S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
                if (cnt_q == 32'd0) begin
                    shcp_d  = 1'b1;
                    cnt_d   = DIV_LAST;
                    state_d = S_SHIFT_HI;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_SHIFT_HI: begin
                if (cnt_q != 32'd0) begin
                    cnt_d = cnt_q - 32'd1;
                end else if (bitcnt_q == 4'd0) begin
                    shcp_d  = 1'b0;
                    stcp_d  = 1'b1;
                    cnt_d   = DIV_LAST;
                    state_d = S_LATCH;
                end else begin
                    bitcnt_d = bitcnt_q - 4'd1;
                    shcp_d   = 1'b0;
                    ds_d     = word_q[bitcnt_d];
                    cnt_d    = DIV_LAST;
                    state_d  = S_SHIFT_LO;
                end
            end
            S_LATCH: begin
                if (cnt_q == 32'd0) begin
                    stcp_d  = 1'b0;
                    shown_d = 1'b1;
                    cnt_d   = SCAN_LAST;
                    state_d = S_DWELL;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_DWELL: begin
                if (cnt_q == 32'd0) begin
                    digit_d = (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Until the first word is latched the 595 outputs hold power-up garbage.
        oe_d = shown_d ? ~seg_en : 1'b1;
    end

    always_comb begin
        pend_data_d  = pend_data_q;
        pend_point_d = pend_point_q;
        pend_blank_d = pend_blank_q;
        pend_valid_d = pend_valid_q;
        act_data_d   = act_data_q;
        act_point_d  = act_point_q;
        act_blank_d  = act_blank_q;
        if (load) begin
            pend_data_d  = data_in;
            pend_point_d = point_in;
            pend_blank_d = blank_in;
            pend_valid_d = 1'b1;
        end
        if (boundary) begin
            if (load) begin
                act_data_d  = data_in;
                act_point_d = point_in;
                act_blank_d = blank_in;
            end else if (pend_valid_q) begin
                act_data_d  = pend_data_q;
                act_point_d = pend_point_q;
                act_blank_d = pend_blank_q;
            end
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bitcnt_q     <= '0;
            word_q       <= '0;
            digit_q      <= '0;
            act_data_q   <= '0;
            act_point_q  <= '0;
            act_blank_q  <= '1;
            pend_data_q  <= '0;
            pend_point_q <= '0;
            pend_blank_q <= '0;
            pend_valid_q <= 1'b0;
            shown_q      <= 1'b0;
            stcp_q       <= 1'b0;
            shcp_q       <= 1'b0;
            ds_q         <= 1'b0;
            oe_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bitcnt_q     <= bitcnt_d;
            word_q       <= word_d;
            digit_q      <= digit_d;
            act_data_q   <= act_data_d;
            act_point_q  <= act_point_d;
            act_blank_q  <= act_blank_d;
            pend_data_q  <= pend_data_d;
            pend_point_q <= pend_point_d;
            pend_blank_q <= pend_blank_d;
            pend_valid_q <= pend_valid_d;
            shown_q      <= shown_d;
            stcp_q       <= stcp_d;
            shcp_q       <= shcp_d;
            ds_q         <= ds_d;
            oe_q         <= oe_d;
        end
    end

    assign frame_done = boundary;
    assign stcp       = stcp_q;
    assign shcp       = shcp_q;
    assign ds         = ds_q;
    assign oe         = oe_q;

endmodule

// File: tb/tb_seg_scan_595_ctrl.sv
// tb/tb_seg_scan_595_ctrl.sv - directed self-checking bench for seg_scan_595_ctrl
module tb_seg_scan_595_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] data_in;
    logic [5:0]  point_in;
    logic [5:0]  blank_in;
    logic        load;
    logic        seg_en;
    logic        frame_done;
    logic        stcp;
    logic        shcp;
    logic        ds;
    logic        oe;

    seg_scan_595_ctrl #(.CLK_DIV(1), .SCAN_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .point_in   (point_in),
        .blank_in   (blank_in),
        .load       (load),
        .seg_en     (seg_en),
        .frame_done (frame_done),
        .stcp       (stcp),
        .shcp       (shcp),
        .ds         (ds),
        .oe         (oe)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: rebuilds each shifted word and records latch/frame timing.
    logic        mon_en = 1'b0;
    logic        shcp_p = 1'b0, stcp_p = 1'b0, ds_p = 1'b0, seen_fall = 1'b0;
    logic [13:0] sh_word = '0;
    int          sh_cnt = 0, stcp_w = 0, ds_bad = 0, oe_early_bad = 0;
    logic [13:0] words[$];
    int          sh_cnts[$];
    int          rise_cyc[$];
    int          widths[$];
    logic        oe_lat[$];
    int          fd_cyc[$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (shcp && !shcp_p) begin
                sh_word = {sh_word[12:0], ds};
                sh_cnt++;
                if (ds !== ds_p) ds_bad++;
            end
            if (stcp && !stcp_p) begin
                words.push_back(sh_word);
                sh_cnts.push_back(sh_cnt);
                rise_cyc.push_back(cyc);
                oe_lat.push_back(oe);
                sh_cnt = 0;
                stcp_w = 0;
            end
            if (stcp) stcp_w++;
            if (!stcp && stcp_p) begin
                widths.push_back(stcp_w);
                seen_fall = 1'b1;
            end
            if (!seen_fall && oe !== 1'b1) oe_early_bad++;
            if (frame_done) fd_cyc.push_back(cyc);
        end
        shcp_p = shcp;
        stcp_p = stcp;
        ds_p   = ds;
    end

    logic [7:0] exp_seg [0:6][0:5];

    task automatic wait_fd(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 400);
        if (!frame_done) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_load(input logic [23:0] d, input logic [5:0] p, input logic [5:0] b);
        data_in  = d;
        point_in = p;
        blank_in = b;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    initial begin
        logic [13:0] exp_w;
        int n;

        for (int f = 0; f < 7; f++)
            for (int d = 0; d < 6; d++)
                exp_seg[f][d] = 8'hFF;
`ifdef SEG_LZ_SUPPRESS_EN
        exp_seg[1] = '{8'hF8, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        exp_seg[4] = '{8'hC0, 8'hF8, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
        exp_seg[1] = '{8'hF8, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        exp_seg[4] = '{8'hC0, 8'hF8, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif
        exp_seg[2] = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        exp_seg[3] = '{8'h02, 8'hFF, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        exp_seg[5] = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88};
        exp_seg[6] = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88};

        rst = 1'b1; load = 1'b0; seg_en = 1'b1;
        data_in = '0; point_in = '0; blank_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_stcp", stcp, 1'b0);
        check_eq("rst_shcp", shcp, 1'b0);
        check_eq("rst_ds", ds, 1'b0);
        check_eq("rst_oe", oe, 1'b1);
        check_eq("rst_frame_done", frame_done, 1'b0);
        rst    = 1'b0;
        mon_en = 1'b1;

        do_load(24'h000007, 6'b0, 6'b0);
        wait_fd("fd1");
        repeat (80) @(negedge clk);
        do_load(24'h123456, 6'b0, 6'b0);
        wait_fd("fd2");
        repeat (80) @(negedge clk);
        do_load(24'h123456, 6'b000001, 6'b000010);
        wait_fd("fd3");
        seg_en = 1'b0;
        repeat (80) @(negedge clk);
        do_load(24'h000070, 6'b0, 6'b0);
        wait_fd("fd4");
        seg_en = 1'b1;
        repeat (80) @(negedge clk);
        do_load(24'h000001, 6'b0, 6'b0);
        repeat (123) @(negedge clk);
        check_eq("fd_at_boundary", frame_done, 1'b1);
        do_load(24'hABCDEF, 6'b0, 6'b0);
        wait_fd("fd6");
        wait_fd("fd7");
        repeat (5) @(negedge clk);
        mon_en = 1'b0;

        check_eq("word_count_ge42", words.size() >= 42, 1'b1);
        if (words.size() >= 42 && widths.size() >= 42) begin
            for (int k = 0; k < 42; k++) begin
                exp_w = {exp_seg[k / 6][k % 6], 6'b000001 << (k % 6)};
                check_eq($sformatf("word%0d", k), words[k], exp_w);
                check_eq($sformatf("shcp_rises%0d", k), sh_cnts[k], 14);
                check_eq($sformatf("stcp_width%0d", k), widths[k], 1);
                check_eq($sformatf("oe_at_latch%0d", k), oe_lat[k],
                         (k == 0 || (k >= 18 && k < 24)) ? 1'b1 : 1'b0);
                if (k > 0) check_eq($sformatf("slot_len%0d", k), rise_cyc[k] - rise_cyc[k-1], 34);
            end
        end
        check_eq("fd_count_ge7", fd_cyc.size() >= 7, 1'b1);
        if (fd_cyc.size() >= 7) begin
            for (int i = 1; i < 7; i++)
                check_eq($sformatf("fd_period%0d", i), fd_cyc[i] - fd_cyc[i-1], 204);
        end
        check_eq("ds_change_on_rise", ds_bad, 0);
        check_eq("oe_before_first_latch", oe_early_bad, 0);

        n = 0;
        while (shcp !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("midshift_shcp_high", shcp, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_stcp", stcp, 1'b0);
        check_eq("midrst_shcp", shcp, 1'b0);
        check_eq("midrst_ds", ds, 1'b0);
        check_eq("midrst_oe", oe, 1'b1);
        check_eq("midrst_frame_done", frame_done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
